ap_mem_responder: RTL and testbench

AP_MEM_RESPONDER -- requirements
Module: ap_mem_responder

---
 rtl/ap_mem_pkg.sv | 20 ++
 rtl/ap_mem_rdpipe.sv | 61 ++++++
 rtl/ap_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_ap_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_mem_pkg.sv
// Shared types and constants for the ap_mem_responder memory slice.
package ap_mem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned AP_ADDR_W  = 32;
    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } mem_state_e;

    // One read result travelling down the latency line; host=1 routes it to the host port.
    typedef struct packed {
        logic              valid;
        logic              host;
        logic [DATA_W-1:0] data;
    } rd_beat_t;

endpackage

// File: rtl/ap_mem_rdpipe.sv
// Read-latency delay line: RD_LAT-1 plain delay stages followed by the output
// register stage, so a beat entering at edge T lands on the outputs at edge T+RD_LAT-1.
// Ports:
//   ap_clk, ap_rst_n : clock, synchronous active-low reset (flushes all stages)
//   in_beat          : read result captured at the current edge
//   q0               : kernel read data, held until the next kernel result
//   host_rdata       : host read data, held until the next host result
//   host_rvalid      : one-cycle pulse with each host result
module ap_mem_rdpipe
    import ap_mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  rd_beat_t          in_beat,
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid
);

    rd_beat_t tap;

    generate
        if (RD_LAT > 1) begin : g_delay
            rd_beat_t [RD_LAT-2:0] stage_q;
            rd_beat_t [RD_LAT-1:0] shift;

            assign shift = {stage_q, in_beat};
            assign tap   = shift[RD_LAT-1];

            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= shift[RD_LAT-2:0];
                end
            end
        end else begin : g_direct
            assign tap = in_beat;
        end
    endgenerate

    // Output stage: steer by source tag, kernel data sticks between reads.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            q0          <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= tap.valid & tap.host;
            if (tap.valid && !tap.host) begin
                q0 <= tap.data;
            end
            if (tap.valid && tap.host) begin
                host_rdata <= tap.data;
            end
        end
    end

endmodule

// File: rtl/ap_mem_responder.sv
// Single-port word memory shared by an HLS kernel port (priority) and a host
// port. After reset the array is cleared one word per cycle before serving.
// Optional feature macro: MEM_RSP_BOUNDS_CHECK_EN (out-of-range accesses are
// dropped / read as 0 and flagged on oob_err; otherwise addresses wrap).
// Ports:
//   ap_clk, ap_rst_n          : clock, synchronous active-low reset
//   ce0, we0, address0, ad0   : kernel access enable, write enable, word address, write data
//   q0                        : kernel read data
//   host_valid, host_we       : host request, write(1)/read(0)
//   host_addr, host_wdata     : host word address, write data
//   host_ready                : host request accepted this cycle (combinational on ce0)
//   host_rvalid, host_rdata   : host read result pulse and data
//   init_done                 : clear finished, serving
//   oob_err                   : sticky out-of-range flag
module ap_mem_responder
    import ap_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ce0,
    input  logic                 we0,
    input  logic [AP_ADDR_W-1:0] address0,
    input  logic [DATA_W-1:0]    ad0,
    output logic [DATA_W-1:0]    q0,
    input  logic                 host_valid,
    input  logic                 host_we,
    input  logic [AP_ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_ready,
    output logic                 host_rvalid,
    output logic [DATA_W-1:0]    host_rdata,
    output logic                 init_done,
    output logic                 oob_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    mem_state_e        state_q, state_d;
    logic [IDX_W-1:0]  clr_q, clr_d;
    logic [IDX_W-1:0]  k_idx, h_idx;
    logic              k_oob, h_oob;
    logic              k_wr, k_rd, h_wr, h_rd;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              oob_hit;
    rd_beat_t          rd_beat;

    assign k_idx = address0[IDX_W-1:0];
    assign h_idx = host_addr[IDX_W-1:0];

`ifdef MEM_RSP_BOUNDS_CHECK_EN
    assign k_oob = |address0[AP_ADDR_W-1:IDX_W];
    assign h_oob = |host_addr[AP_ADDR_W-1:IDX_W];
`else
    // Upper address bits are ignored: addresses wrap inside the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{address0[AP_ADDR_W-1:IDX_W], host_addr[AP_ADDR_W-1:IDX_W], oob_hit};
    assign k_oob = 1'b0;
    assign h_oob = 1'b0;
`endif

    // Kernel wins the single port; host only gets in on idle kernel cycles.
    assign host_ready = (state_q == ST_SERVE) && !ce0;
    assign k_wr       = ce0 & we0;
    assign k_rd       = ce0 & ~we0;
    assign h_wr       = host_valid & host_ready & host_we;
    assign h_rd       = host_valid & host_ready & ~host_we;

    // Next state, clear sweep and single-port access arbitration.
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        mem_we    = 1'b0;
        mem_waddr = clr_q;
        mem_wdata = '0;
        oob_hit   = 1'b0;
        rd_beat   = '0;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                clr_d  = clr_q + IDX_W'(1);
                if (clr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (k_wr) begin
                    mem_we    = ~k_oob;
                    mem_waddr = k_idx;
                    mem_wdata = ad0;
                    oob_hit   = k_oob;
                end else if (k_rd) begin
                    rd_beat.valid = 1'b1;
                    rd_beat.host  = 1'b0;
                    rd_beat.data  = k_oob ? '0 : mem[k_idx];
                    oob_hit       = k_oob;
                end else if (h_wr) begin
                    mem_we    = ~h_oob;
                    mem_waddr = h_idx;
                    mem_wdata = host_wdata;
                    oob_hit   = h_oob;
                end else if (h_rd) begin
                    rd_beat.valid = 1'b1;
                    rd_beat.host  = 1'b1;
                    rd_beat.data  = h_oob ? '0 : mem[h_idx];
                    oob_hit       = h_oob;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q   <= ST_INIT;
            clr_q     <= '0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            init_done <= (state_d == ST_SERVE);
        end
    end

    // Array is read combinationally above, so a same-edge write is never seen (read-first).
    always_ff @(posedge ap_clk) begin
        if (ap_rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef MEM_RSP_BOUNDS_CHECK_EN
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            oob_err <= 1'b0;
        end else if (oob_hit) begin
            oob_err <= 1'b1;
        end
    end
`else
    assign oob_err = 1'b0;
`endif

    ap_mem_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_beat     (rd_beat),
        .q0          (q0),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid)
    );

endmodule

// File: tb/tb_ap_mem_responder.sv
// Bench for ap_mem_responder: two instances (read latency 1 and 3) share one
// stimulus stream and are checked against an event-log reference model.
`timescale 1ns/1ps
module tb_ap_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int KRD = 1;
    localparam int HRD = 2;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ce0 = 1'b0, we0 = 1'b0, host_valid = 1'b0, host_we = 1'b0;
    logic [31:0] address0 = '0, ad0 = '0, host_addr = '0, host_wdata = '0;

    logic [31:0] q0_a, host_rdata_a, q0_b, host_rdata_b;
    logic        host_ready_a, host_rvalid_a, init_done_a, oob_err_a;
    logic        host_ready_b, host_rvalid_b, init_done_b, oob_err_b;

    always #5 ap_clk = ~ap_clk;

    ap_mem_responder #(.DEPTH(DEPTH), .RD_LAT(1)) dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce0(ce0), .we0(we0),
        .address0(address0), .ad0(ad0), .q0(q0_a),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready_a), .host_rvalid(host_rvalid_a),
        .host_rdata(host_rdata_a), .init_done(init_done_a), .oob_err(oob_err_a)
    );

    ap_mem_responder #(.DEPTH(DEPTH), .RD_LAT(3)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce0(ce0), .we0(we0),
        .address0(address0), .ad0(ad0), .q0(q0_b),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready_b), .host_rvalid(host_rvalid_b),
        .host_rdata(host_rdata_b), .init_done(init_done_b), .oob_err(oob_err_b)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: word array plus a log of what each serving edge produced.
    logic [31:0] mem_m [DEPTH];
    int          kind_q [$];
    logic [31:0] val_q  [$];
    logic [31:0] exp_q0  [2];
    logic [31:0] exp_hrd [2];
    logic        exp_rv  [2];
    logic        exp_oob;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
        kind_q.delete();
        val_q.delete();
        for (int i = 0; i < 2; i++) begin
            exp_q0[i] = '0; exp_hrd[i] = '0; exp_rv[i] = 1'b0;
        end
        exp_oob = 1'b0;
    endtask

    task automatic m_read(input logic [31:0] a, output logic [31:0] v);
        v = mem_m[a[5:0]];
`ifdef MEM_RSP_BOUNDS_CHECK_EN
        if (a >= DEPTH) begin
            v = '0;
            exp_oob = 1'b1;
        end
`endif
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
`ifdef MEM_RSP_BOUNDS_CHECK_EN
        if (a >= DEPTH) exp_oob = 1'b1;
        else mem_m[a[5:0]] = d;
`else
        mem_m[a[5:0]] = d;
`endif
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, 7));
        else if (r == 7) return 32'($urandom_range(0, 63));
        else if (r == 8) return 32'(64 + $urandom_range(0, 7));
        else             return $urandom;
    endfunction

    // Outputs after edge n reflect the request logged at edge n-lat+1.
    task automatic chk_outputs();
        for (int i = 0; i < 2; i++) begin
            int lat;
            int j;
            lat = (i == 0) ? 1 : 3;
            j = kind_q.size() - lat;
            exp_rv[i] = 1'b0;
            if (j >= 0) begin
                if (kind_q[j] == KRD) exp_q0[i] = val_q[j];
                if (kind_q[j] == HRD) begin
                    exp_hrd[i] = val_q[j];
                    exp_rv[i]  = 1'b1;
                end
            end
        end
        chk("q0_l1", q0_a, exp_q0[0]);
        chk("q0_l3", q0_b, exp_q0[1]);
        chk("hrvalid_l1", host_rvalid_a, exp_rv[0]);
        chk("hrvalid_l3", host_rvalid_b, exp_rv[1]);
        chk("hrdata_l1", host_rdata_a, exp_hrd[0]);
        chk("hrdata_l3", host_rdata_b, exp_hrd[1]);
        chk("oob_l1", oob_err_a, exp_oob);
        chk("oob_l3", oob_err_b, exp_oob);
        chk("init_done_l1", init_done_a, 1'b1);
        chk("init_done_l3", init_done_b, 1'b1);
    endtask

    // One serving cycle: drive at negedge, check ready, model the edge, check outputs.
    task automatic step(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic hv, input logic hw, input logic [31:0] ha, input logic [31:0] hd);
        logic [31:0] v;
        int k;
        ce0 = c; we0 = w; address0 = a; ad0 = d;
        host_valid = hv; host_we = hw; host_addr = ha; host_wdata = hd;
        #1;
        chk("host_ready_l1", host_ready_a, !c);
        chk("host_ready_l3", host_ready_b, !c);
        k = 0;
        v = '0;
        if (c && w)        m_write(a, d);
        else if (c)        begin m_read(a, v);  k = KRD; end
        else if (hv && hw) m_write(ha, hd);
        else if (hv)       begin m_read(ha, v); k = HRD; end
        @(posedge ap_clk);
        kind_q.push_back(k);
        val_q.push_back(v);
        @(negedge ap_clk);
        chk_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Clear phase: random traffic must be ignored; count edges until init_done.
    task automatic wait_init(input string tag);
        int cnt_a;
        int cnt_b;
        cnt_a = -1;
        cnt_b = -1;
        for (int n = 1; n <= 200; n++) begin
            ce0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
            address0 = 32'($urandom_range(0, 63)); ad0 = $urandom;
            host_valid = 1'($urandom_range(0, 1)); host_we = 1'($urandom_range(0, 1));
            host_addr = 32'($urandom_range(0, 63)); host_wdata = $urandom;
            #1;
            chk({tag, "_ready_init_l1"}, host_ready_a, 1'b0);
            chk({tag, "_ready_init_l3"}, host_ready_b, 1'b0);
            @(posedge ap_clk);
            @(negedge ap_clk);
            if (cnt_a < 0 && init_done_a) cnt_a = n;
            if (cnt_b < 0 && init_done_b) cnt_b = n;
            chk({tag, "_q0_init_l1"}, q0_a, '0);
            chk({tag, "_q0_init_l3"}, q0_b, '0);
            chk({tag, "_rvalid_init_l1"}, host_rvalid_a, 1'b0);
            chk({tag, "_rvalid_init_l3"}, host_rvalid_b, 1'b0);
            if (cnt_a >= 0 && cnt_b >= 0) break;
        end
        chk({tag, "_init_cycles_l1"}, 32'(cnt_a), 32'd64);
        chk({tag, "_init_cycles_l3"}, 32'(cnt_b), 32'd64);
    endtask

    task automatic apply_reset(input string tag);
        ap_rst_n = 1'b0;
        ce0 = 1'b0; we0 = 1'b0; host_valid = 1'b0; host_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            chk({tag, "_rst_rvalid_l1"}, host_rvalid_a, 1'b0);
            chk({tag, "_rst_rvalid_l3"}, host_rvalid_b, 1'b0);
        end
        chk({tag, "_rst_q0_l1"}, q0_a, '0);
        chk({tag, "_rst_q0_l3"}, q0_b, '0);
        chk({tag, "_rst_hrdata_l1"}, host_rdata_a, '0);
        chk({tag, "_rst_hrdata_l3"}, host_rdata_b, '0);
        chk({tag, "_rst_init_done_l1"}, init_done_a, 1'b0);
        chk({tag, "_rst_init_done_l3"}, init_done_b, 1'b0);
        chk({tag, "_rst_oob_l1"}, oob_err_a, 1'b0);
        chk({tag, "_rst_oob_l3"}, oob_err_b, 1'b0);
        chk({tag, "_rst_ready_l1"}, host_ready_a, 1'b0);
        chk({tag, "_rst_ready_l3"}, host_ready_b, 1'b0);
        m_reset();
        ap_rst_n = 1'b1;
        wait_init(tag);
    endtask

    initial begin
        m_reset();
        @(negedge ap_clk);
        apply_reset("por");

        // Fresh memory reads as zero.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'($urandom_range(0, 63)), '0, 1'b0, 1'b0, '0, '0);

        // Kernel write then read of word 5.
        step(1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'd5, '0, 1'b0, 1'b0, '0, '0);
        chk("wr_rd_addr5_l1", q0_a, 32'hDEADBEEF);

        // Latency-3 burst of three reads.
        step(1'b1, 1'b1, 32'd0, 32'd10, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 32'd1, 32'd20, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 32'd2, 32'd30, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'd0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'd1, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'd2, '0, 1'b0, 1'b0, '0, '0);
        chk("burst0_l3", q0_b, 32'd10);
        idle();
        chk("burst1_l3", q0_b, 32'd20);
        idle();
        chk("burst2_l3", q0_b, 32'd30);
        idle();
        chk("burst_hold_l3", q0_b, 32'd30);

        // Host read blocked by kernel activity, accepted once ce0 drops.
        step(1'b1, 1'b1, 32'd3, 32'h33, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'd7, '0, 1'b1, 1'b0, 32'd3, '0);
        step(1'b1, 1'b0, 32'd6, '0, 1'b1, 1'b0, 32'd3, '0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd3, '0);
        chk("host_rd_pulse_l1", host_rvalid_a, 1'b1);
        chk("host_rd_data_l1", host_rdata_a, 32'h33);
        chk("host_rd_early_l3", host_rvalid_b, 1'b0);
        idle();
        idle();
        chk("host_rd_pulse_l3", host_rvalid_b, 1'b1);
        chk("host_rd_data_l3", host_rdata_b, 32'h33);

        // Back-to-back host writes then host reads.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'(8 + i), 32'(100 + i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'(8 + i), '0);
        idle(); idle(); idle();

        // Address 64: dropped and flagged, or wraps onto word 0.
        step(1'b1, 1'b1, 32'd0, 32'h1111, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 32'd64, 32'h9999, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 32'd0, '0, 1'b0, 1'b0, '0, '0);
`ifdef MEM_RSP_BOUNDS_CHECK_EN
        chk("addr64_word0", q0_a, 32'h1111);
        chk("addr64_oob", oob_err_a, 1'b1);
`else
        chk("addr64_word0", q0_a, 32'h9999);
        chk("addr64_oob", oob_err_a, 1'b0);
`endif

        // Random mixed traffic.
        for (int n = 0; n < 600; n++) begin
            logic c, w, hv, hw;
            c  = ($urandom_range(0, 2) == 0);
            w  = 1'($urandom_range(0, 1));
            hv = 1'($urandom_range(0, 1));
            hw = 1'($urandom_range(0, 1));
            step(c, w, rand_addr(), $urandom, hv, hw, rand_addr(), $urandom);
        end

        // Reset with a host read in flight.
        idle(); idle(); idle();
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd3, '0);
        apply_reset("mid");
        step(1'b1, 1'b0, 32'd5, '0, 1'b0, 1'b0, '0, '0);
        chk("cleared_addr5_l1", q0_a, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'(i), '0);
        idle(); idle(); idle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Watchdog: the run must end on its own.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
